// File: rtl/alu_pkg.sv
// Shared definitions for the integer execute-unit adder.
//   alu_op_e    : operation encodings (ADD/SUB/ADDW/SUBW)
//   TagW        : destination tag width
//   GroupW      : width of one carry-lookahead group
//   cla4_carry  : carries into four positions, fully expanded lookahead
//   cla4_gen    : block generate of four (g, p) pairs
package alu_pkg;

  localparam int unsigned TagW   = 5;
  localparam int unsigned GroupW = 16;

  typedef enum logic [1:0] {
    OpAdd  = 2'b00,
    OpSub  = 2'b01,
    OpAddw = 2'b10,
    OpSubw = 2'b11
  } alu_op_e;

  function automatic logic [3:0] cla4_carry(input logic [3:0] g, input logic [3:0] p,
                                            input logic ci);
    logic [3:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  function automatic logic cla4_gen(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

endpackage

// File: rtl/cla_group16.sv
// Combinational 16-bit two-level carry-lookahead group.
//   a, b : operand slices
//   ci   : carry into the group
//   sum  : a + b + ci
//   gm   : group generate (independent of ci)
//   pm   : group propagate (independent of ci)
module cla_group16 import alu_pkg::*; (
  input  logic [GroupW-1:0] a,
  input  logic [GroupW-1:0] b,
  input  logic              ci,
  output logic [GroupW-1:0] sum,
  output logic              gm,
  output logic              pm
);

  logic [GroupW-1:0] g, p, c;
  logic [3:0]        blk_g, blk_p, blk_c;

  always_comb begin
    g = a & b;
    p = a ^ b;
    // Level 1: nibble generate/propagate.
    for (int k = 0; k < 4; k++) begin
      blk_g[k] = cla4_gen(g[4*k +: 4], p[4*k +: 4]);
      blk_p[k] = &p[4*k +: 4];
    end
    // Level 2: nibble carries, then bit carries inside each nibble.
    blk_c = cla4_carry(blk_g, blk_p, ci);
    for (int k = 0; k < 4; k++) begin
      c[4*k +: 4] = cla4_carry(g[4*k +: 4], p[4*k +: 4], blk_c[k]);
    end
    gm  = cla4_gen(blk_g, blk_p);
    pm  = &blk_p;
    sum = p ^ c;
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
//   clk, rst_n                  : clock, async active-low reset
//   in_valid/in_ready           : operand beat handshake
//   in_op                       : 00 ADD, 01 SUB, 10 ADDW, 11 SUBW
//   in_a, in_b, in_tag          : operands and pass-through tag
//   out_valid/out_ready         : result handshake
//   out_sum, out_co, out_ovf,
//   out_zero, out_tag           : result, carry (no-borrow for SUB), overflow, zero, tag
// STAGES=1 registers only the outputs; STAGES=2 adds a register holding carry-select group
// sums and group G/P, with carry resolution in the second stage.
module cla_pipe_adder import alu_pkg::*; #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned STAGES   = 2,
  parameter int unsigned WORD_OPS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [TagW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_sum,
  output logic            out_co,
  output logic            out_ovf,
  output logic            out_zero,
  output logic [TagW-1:0] out_tag
);

  localparam int NGroups = XLEN / GroupW;
  localparam bit WordEn  = (WORD_OPS != 0) && (XLEN == 64);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("cla_pipe_adder: XLEN must be 32 or 64");
  end
  if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
    $error("cla_pipe_adder: STAGES must be 1 or 2");
  end

  typedef struct packed {
    logic [XLEN-1:0]    s0;     // group sums assuming carry-in 0
    logic [XLEN-1:0]    s1;     // group sums assuming carry-in 1
    logic [NGroups-1:0] gm;
    logic [NGroups-1:0] pm;
    logic               cin;
    logic               word;
    logic               p_msb;  // propagate at XLEN-1, recovers carry into the MSB
    logic               p_w31;  // propagate at bit 31, same for word ops
    logic [TagW-1:0]    tag;
  } mid_t;

  // Front end: group generation.
  logic [XLEN-1:0]    b_eff, s0_w, s1_w;
  logic [NGroups-1:0] gm_w, pm_w;
  logic               is_sub;
  mid_t               front, mid;
  logic               mid_valid, out_rdy;

  assign is_sub = in_op[0];
  assign b_eff  = is_sub ? ~in_b : in_b;

  for (genvar j = 0; j < NGroups; j++) begin : g_grp
    // G/P do not depend on Ci, so each copy supplies one of them.
    cla_group16 u_sel0 (
      .a  (in_a[j*GroupW +: GroupW]),
      .b  (b_eff[j*GroupW +: GroupW]),
      .ci (1'b0),
      .sum(s0_w[j*GroupW +: GroupW]),
      .gm (gm_w[j]),
      .pm ()
    );
    cla_group16 u_sel1 (
      .a  (in_a[j*GroupW +: GroupW]),
      .b  (b_eff[j*GroupW +: GroupW]),
      .ci (1'b1),
      .sum(s1_w[j*GroupW +: GroupW]),
      .gm (),
      .pm (pm_w[j])
    );
  end

  always_comb begin
    front       = '0;
    front.s0    = s0_w;
    front.s1    = s1_w;
    front.gm    = gm_w;
    front.pm    = pm_w;
    front.cin   = is_sub;
    front.word  = WordEn && in_op[1];
    front.p_msb = in_a[XLEN-1] ^ b_eff[XLEN-1];
    front.p_w31 = in_a[31] ^ b_eff[31];
    front.tag   = in_tag;
  end

  assign out_rdy = !out_valid || out_ready;

  if (STAGES == 2) begin : g_mid
    logic mid_valid_q;
    mid_t mid_q;

    assign in_ready = !mid_valid_q || out_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mid_valid_q <= 1'b0;
        mid_q       <= '0;
      end else if (in_ready) begin
        mid_valid_q <= in_valid;
        if (in_valid) mid_q <= front;
      end
    end

    assign mid_valid = mid_valid_q;
    assign mid       = mid_q;
  end else begin : g_nomid
    assign in_ready  = out_rdy;
    assign mid_valid = in_valid;
    assign mid       = front;
  end

  // Back end: group-carry lookahead, carry-select and flags.
  logic [NGroups:0] gc;
  logic [XLEN-1:0]  sum_sel, res;
  logic             term, co_d, ovf_d, zero_d;

  always_comb begin
    term = 1'b0;
    // gc[j] = cin & P[0..j-1]  |  OR_k ( G[k] & P[k+1..j-1] ), flattened per group.
    for (int j = 0; j <= NGroups; j++) begin
      gc[j] = mid.cin;
      for (int k = 0; k < j; k++) gc[j] = gc[j] & mid.pm[k];
      for (int k = 0; k < j; k++) begin
        term = mid.gm[k];
        for (int m = k + 1; m < j; m++) term = term & mid.pm[m];
        gc[j] = gc[j] | term;
      end
    end
    for (int j = 0; j < NGroups; j++) begin
      sum_sel[j*GroupW +: GroupW] = gc[j] ? mid.s1[j*GroupW +: GroupW]
                                          : mid.s0[j*GroupW +: GroupW];
    end
    res   = sum_sel;
    co_d  = gc[NGroups];
    // Carry into a bit is sum ^ propagate at that bit.
    ovf_d = (sum_sel[XLEN-1] ^ mid.p_msb) ^ gc[NGroups];
    if (mid.word) begin
      for (int i = 32; i < XLEN; i++) res[i] = sum_sel[31];
      co_d  = gc[2];
      ovf_d = (sum_sel[31] ^ mid.p_w31) ^ gc[2];
    end
    zero_d = (res == '0);
  end

  logic            out_valid_q, co_q, ovf_q, zero_q;
  logic [XLEN-1:0] sum_q;
  logic [TagW-1:0] tag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      co_q        <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      tag_q       <= '0;
    end else if (out_rdy) begin
      out_valid_q <= mid_valid;
      if (mid_valid) begin
        sum_q  <= res;
        co_q   <= co_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
        tag_q  <= mid.tag;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_co    = co_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;
  assign out_tag   = tag_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
module tb_cla_pipe_adder;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 64-bit, two-stage instance
  logic        in_valid_64, in_ready_64, out_valid_64, out_ready_64;
  logic [1:0]  in_op_64;
  logic [63:0] in_a_64, in_b_64, out_sum_64;
  logic [4:0]  in_tag_64, out_tag_64;
  logic        out_co_64, out_ovf_64, out_zero_64;

  // 32-bit, single-stage instance
  logic        in_valid_32, in_ready_32, out_valid_32, out_ready_32;
  logic [1:0]  in_op_32;
  logic [31:0] in_a_32, in_b_32, out_sum_32;
  logic [4:0]  in_tag_32, out_tag_32;
  logic        out_co_32, out_ovf_32, out_zero_32;

  cla_pipe_adder #(.XLEN(64), .STAGES(2), .WORD_OPS(1)) u_dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_64), .in_ready(in_ready_64), .in_op(in_op_64),
    .in_a(in_a_64), .in_b(in_b_64), .in_tag(in_tag_64),
    .out_valid(out_valid_64), .out_ready(out_ready_64), .out_sum(out_sum_64),
    .out_co(out_co_64), .out_ovf(out_ovf_64), .out_zero(out_zero_64), .out_tag(out_tag_64)
  );

  cla_pipe_adder #(.XLEN(32), .STAGES(1), .WORD_OPS(1)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_32), .in_ready(in_ready_32), .in_op(in_op_32),
    .in_a(in_a_32), .in_b(in_b_32), .in_tag(in_tag_32),
    .out_valid(out_valid_32), .out_ready(out_ready_32), .out_sum(out_sum_32),
    .out_co(out_co_32), .out_ovf(out_ovf_32), .out_zero(out_zero_32), .out_tag(out_tag_32)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive64(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] tag);
    in_valid_64 = 1'b1;
    in_op_64    = op;
    in_a_64     = a;
    in_b_64     = b;
    in_tag_64   = tag;
  endtask

  // Issue one beat to the 64-bit unit; returns when the result should be at the output.
  task automatic beat64(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] tag);
    drive64(op, a, b, tag);
    step();
    in_valid_64 = 1'b0;
    chk("lat64_not_early", out_valid_64, 1'b0);
    step();
    chk("lat64_valid", out_valid_64, 1'b1);
  endtask

  task automatic flags64(input string name, input logic [63:0] sum, input logic co,
                         input logic ovf, input logic zero);
    chk({name, "_sum"}, out_sum_64, sum);
    chk({name, "_co"}, out_co_64, co);
    chk({name, "_ovf"}, out_ovf_64, ovf);
    chk({name, "_zero"}, out_zero_64, zero);
  endtask

  logic [4:0]  gtag [4];
  logic [63:0] gsum [4];
  int          got, nt;
  logic        acc;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_valid_64 = 1'b0; in_op_64 = 2'b00; in_a_64 = '0; in_b_64 = '0; in_tag_64 = '0;
    out_ready_64 = 1'b1;
    in_valid_32 = 1'b0; in_op_32 = 2'b00; in_a_32 = '0; in_b_32 = '0; in_tag_32 = '0;
    out_ready_32 = 1'b1;

    // Reset state
    step();
    step();
    chk("rst_valid64", out_valid_64, 1'b0);
    chk("rst_sum64", out_sum_64, 64'h0);
    chk("rst_flags64", {out_co_64, out_ovf_64, out_zero_64}, 3'b000);
    chk("rst_tag64", out_tag_64, 5'd0);
    chk("rst_valid32", out_valid_32, 1'b0);
    chk("rst_sum32", out_sum_32, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready64", in_ready_64, 1'b1);
    chk("rst_in_ready32", in_ready_32, 1'b1);

    // ADD wrapping to zero
    beat64(OpAdd, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 5'd3);
    flags64("add_wrap", 64'h0, 1'b1, 1'b0, 1'b1);
    chk("add_wrap_tag", out_tag_64, 5'd3);

    // SUB signed overflow at the MSB
    beat64(OpSub, 64'h8000_0000_0000_0000, 64'h1, 5'd4);
    flags64("sub_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);

    // ADDW with upper garbage, sign-extended overflow
    beat64(OpAddw, 64'h1234_5678_7FFF_FFFF, 64'h1, 5'd5);
    flags64("addw_ovf", 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b1, 1'b0);

    // SUB with borrow
    beat64(OpSub, 64'h5, 64'h7, 5'd6);
    flags64("sub_borrow", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);

    // SUBW ignores upper bits, zero result
    beat64(OpSubw, 64'hDEAD_BEEF_0000_0003, 64'h1234_0000_0000_0003, 5'd7);
    flags64("subw_zero", 64'h0, 1'b1, 1'b0, 1'b1);

    // Carry rippling across three group boundaries
    beat64(OpAdd, 64'h0000_FFFF_FFFF_FFFF, 64'h1, 5'd8);
    flags64("add_grp", 64'h0001_0000_0000_0000, 1'b0, 1'b0, 1'b0);
    step();
    chk("drain_idle", out_valid_64, 1'b0);

    // Back-pressure: consumer stalls for five edges
    out_ready_64 = 1'b0;
    drive64(OpAdd, 64'h100, 64'h0, 5'd0);
    chk("bp_in_ready_empty", in_ready_64, 1'b1);
    step();
    drive64(OpAdd, 64'h101, 64'h0, 5'd1);
    chk("bp_out_empty", out_valid_64, 1'b0);
    chk("bp_in_ready_half", in_ready_64, 1'b1);
    step();
    drive64(OpAdd, 64'h102, 64'h0, 5'd2);
    chk("bp_full_in_ready", in_ready_64, 1'b0);
    chk("bp_head_tag", out_tag_64, 5'd0);
    chk("bp_head_sum", out_sum_64, 64'h100);
    step();
    for (int c = 0; c < 2; c++) begin
      chk("bp_stall_valid", out_valid_64, 1'b1);
      chk("bp_stall_sum", out_sum_64, 64'h100);
      chk("bp_stall_tag", out_tag_64, 5'd0);
      chk("bp_stall_in_ready", in_ready_64, 1'b0);
      step();
    end
    out_ready_64 = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready_64, 1'b1);
    nt  = 2;
    got = 0;
    for (int c = 0; c < 12 && got < 4; c++) begin
      acc = in_valid_64 && in_ready_64;
      if (out_valid_64) begin
        gtag[got] = out_tag_64;
        gsum[got] = out_sum_64;
        got++;
      end
      step();
      if (acc) begin
        nt++;
        if (nt < 4) drive64(OpAdd, 64'h100 + 64'(nt), 64'h0, 5'(nt));
        else in_valid_64 = 1'b0;
      end
    end
    chk("bp_count", 64'(got), 64'd4);
    for (int k = 0; k < 4; k++) begin
      chk("bp_order_tag", gtag[k], 5'(k));
      chk("bp_order_sum", gsum[k], 64'h100 + 64'(k));
    end
    step();
    chk("bp_drained", out_valid_64, 1'b0);

    // 32-bit, single stage: ADD overflow, SUBW behaves as SUB
    in_valid_32 = 1'b1; in_op_32 = OpAdd; in_a_32 = 32'h7FFF_FFFF; in_b_32 = 32'h1;
    in_tag_32 = 5'd11;
    step();
    in_valid_32 = 1'b0;
    chk("x32_add_valid", out_valid_32, 1'b1);
    chk("x32_add_sum", out_sum_32, 32'h8000_0000);
    chk("x32_add_ovf", out_ovf_32, 1'b1);
    chk("x32_add_co", out_co_32, 1'b0);
    chk("x32_add_tag", out_tag_32, 5'd11);
    in_valid_32 = 1'b1; in_op_32 = OpSubw; in_tag_32 = 5'd12;
    step();
    in_valid_32 = 1'b0;
    chk("x32_subw_valid", out_valid_32, 1'b1);
    chk("x32_subw_sum", out_sum_32, 32'h7FFF_FFFE);
    chk("x32_subw_ovf", out_ovf_32, 1'b0);
    chk("x32_subw_co", out_co_32, 1'b1);
    chk("x32_subw_zero", out_zero_32, 1'b0);
    step();
    chk("x32_idle", out_valid_32, 1'b0);

    // Reset with two beats in flight
    drive64(OpAdd, 64'h3, 64'h4, 5'd7);
    step();
    drive64(OpAdd, 64'h1, 64'h1, 5'd8);
    step();
    in_valid_64 = 1'b0;
    chk("mid_rst_pre_valid", out_valid_64, 1'b1);
    chk("mid_rst_pre_sum", out_sum_64, 64'h7);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid_64, 1'b0);
    chk("mid_rst_sum", out_sum_64, 64'h0);
    chk("mid_rst_flags", {out_co_64, out_ovf_64, out_zero_64}, 3'b000);
    chk("mid_rst_tag", out_tag_64, 5'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("mid_rst_dropped", out_valid_64, 1'b0);
    beat64(OpAdd, 64'h5, 64'h7, 5'd9);
    flags64("post_rst", 64'd12, 1'b0, 1'b0, 1'b0);
    chk("post_rst_tag", out_tag_64, 5'd9);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
